tape_mem_ctrl: RTL
==================

Name: tape_mem_ctrl

Overview:
Byte-granular initiator for the 16-bit x 16K single-port SPRAM wrapper. It turns CPU tape requests (READ, WRITE, ADD) into SPRAM word accesses with nibble write masks, and returns responses at fixed latency. ADD is a read-modify-write step, so the core can execute `+`/`-` as one request. The block sits between the core's data-pointer datapath and the SPRAM wrapper instance.

Parameters:
- WORDS, 16384: SPRAM depth in 16-bit words; fixed by the macro.
- WORD_AW, 14: word address width, equal to clog2(WORDS).
- BYTE_AW, 15: byte address width, equal to WORD_AW+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  tape_pkg::op_t: READ=0, WRITE=1, ADD=2; 3 is reserved
- req_addr  in  15  byte address
- req_wdata  in  8  write data for WRITE, or delta for ADD (mod 256)
- rsp_valid  out  1  one-cycle response strobe; there is no backpressure
- rsp_data  out  8  byte value: read value, written value, or post-ADD value
- mem_we  out  4  SPRAM nibble write mask
- mem_addr  out  14  SPRAM word address
- mem_din  out  16  SPRAM write data
- mem_dout  in  16  SPRAM read data, valid the cycle after the address edge

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, mem_we=0, mem_addr=0, mem_din=0.
  - State is CLEAR if TAPE_CLEAR_EN is defined, otherwise IDLE.
- Address mapping:
  - Word address = req_addr[14:1].
  - Lane = req_addr[0]. Lane 0 is bits [7:0] with mask 4'b0011. Lane 1 is bits [15:8] with mask 4'b1100.
  - Write data is the byte replicated on both halves of mem_din.
- Handshake:
  - A request is accepted on a clk edge where req_valid and req_ready are both 1.
  - In IDLE, mem_addr, mem_we and mem_din are driven combinationally from the request whenever req_valid=1, so the SPRAM samples them on the accept edge.
  - mem_we is nonzero only for an accepted WRITE.
- States:
  - IDLE: req_ready=1.
    - Accepting READ or WRITE stays in IDLE.
    - Accepting ADD goes to ADD_WR.
    - Reserved op 3 is accepted, behaves as READ, and has no write side effect.
  - ADD_WR: req_ready=0 for one cycle.
    - Drives mem_addr = latched word address and mem_we = latched lane mask.
    - Drives mem_din = replicated (mem_dout lane byte + latched delta) mod 256.
    - Returns to IDLE.
  - CLEAR (optional): see Optional Feature.
- Response timing:
  - READ: rsp_valid in the cycle after accept. rsp_data = selected lane of mem_dout.
  - WRITE: rsp_valid in the cycle after accept. rsp_data = written byte.
  - ADD: rsp_valid in the cycle after ADD_WR. rsp_data = the sum, registered.
- Throughput:
  - READ and WRITE can be issued back-to-back, one per cycle.
  - ADD occupies 2 cycles.
- Hazards:
  - A request to the same address immediately after a WRITE or ADD sees the new value; the SPRAM write completes on the preceding edge, so no forwarding is needed.
  - An ADD on one lane leaves the other lane's byte untouched, because of the mask.
- Arithmetic: 8-bit wrap. 0xFF + 0x01 = 0x00; 0x00 + 0xFF = 0xFF.
- Reset mid-operation: any in-flight ADD is abandoned with no write. rsp_valid drops immediately (asynchronous reset).

Optional Feature:
- Macro: TAPE_CLEAR_EN.
- Defined:
  - After reset deassertion, state CLEAR sweeps a 14-bit counter from 0 to 16383.
  - Each cycle drives mem_addr=counter, mem_we=4'hF, mem_din=0.
  - req_ready=0 throughout the sweep.
  - After word 16383 is written, the state becomes IDLE, and req_ready=1 exactly 16384 cycles after the first clk edge with rst_n high.
  - Reset during CLEAR restarts the sweep at 0.
- Undefined: no CLEAR state. IDLE with req_ready=1 from the first edge after reset release; tape contents are undefined.

Decomposition:
- tape_pkg:
  - op_t enum (READ, WRITE, ADD, RSVD)
  - state_t enum (IDLE, ADD_WR, CLEAR)
  - WORDS, WORD_AW, BYTE_AW
  - LANE_MASK_LO=4'b0011, LANE_MASK_HI=4'b1100
- No sub-module: the byte-lane select/merge is a package function. The SPRAM wrapper is instantiated by the parent, not inside this block.

Test Plan:
- Clear sweep (TAPE_CLEAR_EN defined): release reset, count cycles until req_ready=1 -> exactly 16384. Then READ 0x7FFF -> rsp_data=0x00.
- Byte lanes: WRITE 0x0010=0xAB, then WRITE 0x0011=0xCD (back-to-back), then READ 0x0010 and READ 0x0011 -> 0xAB, 0xCD. Check mem_we=4'b0011 then 4'b1100.
- ADD wrap: WRITE 0x0005=0xFF, then ADD 0x0005 delta 0x01 -> rsp_data=0x00. Then ADD delta 0xFF -> 0xFF. Neighbour 0x0004 unchanged. req_ready=0 during each ADD_WR cycle.
- Back-to-back hazard: ADD 0x0100 delta 0x03 from 0x10, immediately followed by READ 0x0100 -> READ response=0x13, one cycle after the ADD response.
- Reset mid-ADD: assert rst_n=0 during ADD_WR -> no SPRAM write (mem_we=0), rsp_valid=0. After recovery, READ returns the old value.
- Random traffic: 10k random ops checked against a byte-array scoreboard -> all responses match, and rsp_valid latency is 1 for READ/WRITE and 2 for ADD.

Source files
------------

// File: rtl/tape_pkg.sv
// tape_pkg: shared types, geometry and byte-lane helpers for the tape memory controller.
// Optional power-on tape clear is enabled by defining TAPE_CLEAR_EN.
package tape_pkg;
  localparam int WORDS   = 16384;
  localparam int WORD_AW = 14;
  localparam int BYTE_AW = 15;
  localparam logic [3:0] LANE_MASK_LO = 4'b0011;
  localparam logic [3:0] LANE_MASK_HI = 4'b1100;
  typedef enum logic [1:0] {READ, WRITE, ADD, RSVD} op_t;
  typedef enum logic [1:0] {IDLE, ADD_WR, CLEAR} state_t;
  function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction
  function automatic logic [3:0] lane_mask(input logic lane);
    return lane ? LANE_MASK_HI : LANE_MASK_LO;
  endfunction
  function automatic logic [15:0] rep(input logic [7:0] b);
    return {b, b};
  endfunction
endpackage

// File: rtl/tape_mem_ctrl.sv
// tape_mem_ctrl: byte-granular READ/WRITE/ADD initiator for a 16-bit x 16K nibble-masked SPRAM.
// Define TAPE_CLEAR_EN to zero the whole tape after reset before accepting requests.
module tape_mem_ctrl
  import tape_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  op_t                req_op,
  input  logic [BYTE_AW-1:0] req_addr,
  input  logic [7:0]         req_wdata,
  output logic               rsp_valid,
  output logic [7:0]         rsp_data,
  output logic [3:0]         mem_we,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [15:0]        mem_din,
  input  logic [15:0]        mem_dout
);
  state_t             r_state;
  logic               r_ready, r_rsp_valid, r_rsp_rd, r_rsp_lane, r_lane;
  logic [7:0]         r_rsp_byte, r_delta;
  logic [WORD_AW-1:0] r_addr;
  logic               w_acc, w_add, w_clr;
  logic [7:0]         w_sum;
  logic [WORD_AW-1:0] w_cnt;
`ifdef TAPE_CLEAR_EN
  logic               r_clr_run;
  logic [WORD_AW-1:0] r_cnt;
  assign w_clr = (r_state == CLEAR) && r_clr_run;
  assign w_cnt = r_cnt;
`else
  assign w_clr = 1'b0;
  assign w_cnt = '0;
`endif
  // r_ready is only ever set while idle, so it also gates the request-driven SPRAM outputs
  assign w_acc = (r_state == IDLE) && r_ready && req_valid;
  assign w_add = (r_state == ADD_WR);
  assign w_sum = lane_sel(mem_dout, r_lane) + r_delta;
  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_rd ? lane_sel(mem_dout, r_rsp_lane) : r_rsp_byte;
  assign mem_addr  = w_add ? r_addr : w_clr ? w_cnt : w_acc ? req_addr[BYTE_AW-1:1] : '0;
  assign mem_we    = w_add ? lane_mask(r_lane) : w_clr ? 4'hF :
                     (w_acc && req_op == WRITE) ? lane_mask(req_addr[0]) : 4'h0;
  assign mem_din   = w_add ? rep(w_sum) : (w_acc && !w_clr) ? rep(req_wdata) : 16'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef TAPE_CLEAR_EN
      r_state   <= CLEAR;
      r_clr_run <= 1'b0;
      r_cnt     <= '0;
`else
      r_state   <= IDLE;
`endif
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rd    <= 1'b0;
      r_rsp_lane  <= 1'b0;
      r_rsp_byte  <= '0;
      r_lane      <= 1'b0;
      r_delta     <= '0;
      r_addr      <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rd    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_acc) begin
            if (req_op == ADD) begin
              r_state <= ADD_WR;
              r_ready <= 1'b0;
              r_addr  <= req_addr[BYTE_AW-1:1];
              r_lane  <= req_addr[0];
              r_delta <= req_wdata;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rd    <= (req_op != WRITE);
              r_rsp_lane  <= req_addr[0];
              r_rsp_byte  <= req_wdata;
            end
          end
        end
        ADD_WR: begin
          r_state     <= IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_byte  <= w_sum;
        end
`ifdef TAPE_CLEAR_EN
        // first edge arms the sweep; the following 16384 edges write words 0..16383
        CLEAR: begin
          if (!r_clr_run) r_clr_run <= 1'b1;
          else begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
              r_state   <= IDLE;
              r_ready   <= 1'b1;
              r_clr_run <= 1'b0;
            end
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
